// File: rtl/dsm_pkg.sv
// Shared constants and the noise-cancellation helper for the MASH delta-sigma modulator.
package dsm_pkg;

    localparam int             DIV_W     = 4;
    localparam int             MAX_ORDER = 3;
    localparam int             LFSR_W    = 15;
    localparam logic [14:0]    LFSR_SEED = 15'h0001;
    // x^15 + x^14 + 1 : feedback from bits 14 and 13
    localparam logic [14:0]    LFSR_TAPS = 15'h6000;

    // Range is -3..+4, so plain modulo-16 arithmetic is an exact 4-bit two's-complement result.
    function automatic logic [DIV_W-1:0] noise_cancel(
        input logic c1,
        input logic c2,
        input logic c2_d1,
        input logic c3,
        input logic c3_d1,
        input logic c3_d2
    );
        logic [DIV_W-1:0] r;
        r = {3'b000, c1}
          + {3'b000, c2} - {3'b000, c2_d1}
          + {3'b000, c3} - {2'b00, c3_d1, 1'b0} + {3'b000, c3_d2};
        return r;
    endfunction

endpackage

// File: rtl/mash_dsm_if.sv
// Data/control bundle between a fractional-word source and the MASH modulator.
interface mash_dsm_if #(
    parameter int WIDTH = 7
);
    logic                       En;
    logic [WIDTH-1:0]           In_Data;
    logic [dsm_pkg::DIV_W-1:0]  Out_Div;
    logic                       Out_Valid;

    modport master (output En, output In_Data, input Out_Div, input Out_Valid);
    modport slave  (input En, input In_Data, output Out_Div, output Out_Valid);
endinterface

// File: rtl/dsm_accum_stage.sv
// One WIDTH-bit accumulator with registered carry-out; exposes its next-state sum for the next stage.
module dsm_accum_stage #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] add_in,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_nxt,
    output logic             carry_q
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_d;
    logic [WIDTH:0]   total;

    always_comb begin
        total   = {1'b0, acc_q} + {1'b0, add_in} + {{WIDTH{1'b0}}, cin};
        acc_d   = acc_q;
        carry_d = carry_q;
        if (en) begin
            acc_d   = total[WIDTH-1:0];
            carry_d = total[WIDTH];
        end
    end

    assign sum_nxt = total[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/mash_dsm.sv
// MASH 1-1-1 delta-sigma modulator producing a divider offset; ORDER stages of dsm_accum_stage.
// Optional LSB dither from a 15-bit LFSR is compiled in with DSM_DITHER_EN.
module mash_dsm
    import dsm_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int ORDER = 3
) (
    input  logic       Clk,
    input  logic       reset,
    mash_dsm_if.slave  bus
);

    localparam logic [2:0] FILL_MAX = 3'(ORDER + 1);

    logic [MAX_ORDER:0][WIDTH-1:0] chain;
    logic [MAX_ORDER-1:0]          carry;
    logic                          dither;

    logic             c2_d1_q, c2_d1_d;
    logic             c3_d1_q, c3_d1_d;
    logic             c3_d2_q, c3_d2_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       fill_q, fill_d;

    assign chain[0] = bus.In_Data;

    // Each stage integrates the same-cycle next-state sum of the stage before it.
    for (genvar k = 0; k < MAX_ORDER; k++) begin : g_stage
        if (k < ORDER) begin : g_on
            dsm_accum_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (Clk),
                .reset   (reset),
                .en      (bus.En),
                .add_in  (chain[k]),
                .cin     ((k == 0) ? dither : 1'b0),
                .sum_nxt (chain[k+1]),
                .carry_q (carry[k])
            );
        end else begin : g_off
            assign chain[k+1] = '0;
            assign carry[k]   = 1'b0;
        end
    end

`ifdef DSM_DITHER_EN
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (bus.En) begin
            lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign dither = lfsr_q[0];
`else
    assign dither = 1'b0;
`endif

    always_comb begin
        c2_d1_d = c2_d1_q;
        c3_d1_d = c3_d1_q;
        c3_d2_d = c3_d2_q;
        div_d   = div_q;
        fill_d  = fill_q;
        if (bus.En) begin
            c2_d1_d = carry[1];
            c3_d1_d = carry[2];
            c3_d2_d = c3_d1_q;
            div_d   = noise_cancel(carry[0], carry[1], c2_d1_q,
                                   carry[2], c3_d1_q, c3_d2_q);
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 3'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            c2_d1_q <= 1'b0;
            c3_d1_q <= 1'b0;
            c3_d2_q <= 1'b0;
            div_q   <= '0;
            fill_q  <= '0;
        end else begin
            c2_d1_q <= c2_d1_d;
            c3_d1_q <= c3_d1_d;
            c3_d2_q <= c3_d2_d;
            div_q   <= div_d;
            fill_q  <= fill_d;
        end
    end

    assign bus.Out_Div   = div_q;
    assign bus.Out_Valid = (fill_q == FILL_MAX);

endmodule

// File: doc/mash_dsm.md
MASH_DSM -- requirements
Module: mash_dsm

Interface
REQ-001 Parameter WIDTH, default 7: accumulator and fractional-input width, legal range 4..24.
REQ-002 Parameter ORDER, default 3: number of cascaded accumulator stages, legal values 1, 2 or 3.
REQ-003 Clk  in  1: single clock; all state updates on the rising edge.
REQ-004 reset  in  1: synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 En  in  1: advance enable; while low, all state holds.
REQ-006 In_Data  in  WIDTH: unsigned fractional word F; nominal mean output is F/2^WIDTH.
REQ-007 Out_Div  out  4: two's-complement divider offset, range -3..+4.
REQ-008 Out_Valid  out  1: high once the pipeline is filled after reset.

Function
REQ-009 Stage 1, on each edge with En=1: {c1,acc1} SHALL be loaded with acc1 + In_Data + d; d is the dither bit, 0 when dithering is not compiled in.
REQ-010 Stage k>1 SHALL add the next-state sum of stage k-1 (the same-cycle value) to acc_k: {c_k,acc_k} <= acc_k + sum_{k-1}, modulo 2^WIDTH, with carry-out c_k.
REQ-011 Carries c_k SHALL be registered; delay registers SHALL hold c2[n-1], c3[n-1] and c3[n-2].
REQ-012 Out_Div SHALL be registered from the following noise-cancellation sum, evaluated on the current carry and delay registers, giving 1 cycle of latency from a carry to Out_Div:
  - ORDER=1: c1
  - ORDER=2: c1 + c2 - c2[n-1]
  - ORDER=3: c1 + c2 - c2[n-1] + c3 - 2*c3[n-1] + c3[n-2]
REQ-013 Stages above ORDER SHALL not be generated; their terms are 0.
REQ-014 The Out_Div arithmetic SHALL be sign-extended to 4 bits with no saturation, since the range is provably -3..+4.
REQ-015 Fill counter: counts enabled cycles after reset, saturating at ORDER+1; Out_Valid=1 once it reaches ORDER+1.
REQ-016 With En=0, accumulators, delays, fill counter, dither state and Out_Div SHALL all hold.
REQ-017 Accumulator wrap-around is modulo 2^WIDTH; the carry is the only overflow indication.
REQ-018 A change of In_Data takes effect on the next enabled edge; no flush is performed.
REQ-019 In_Data=0 with no dither SHALL keep all carries at 0 and Out_Div at 0.

Reset
REQ-020 When reset=1 at an edge: accumulators, carries, delays, Out_Div, Out_Valid and fill counter SHALL be 0, and the LFSR SHALL be 15'h0001.
REQ-021 Reset SHALL take priority over En.
REQ-022 Reset mid-operation SHALL discard all history; behaviour afterwards is identical to behaviour after a power-on reset.

Configuration
REQ-023 With DSM_DITHER_EN defined, a 15-bit LFSR (x^15+x^14+1) SHALL advance on each enabled edge, and its bit 0 SHALL be d in stage 1.
REQ-024 Without DSM_DITHER_EN, no LFSR SHALL exist, and d=0 at all times.

Structure
REQ-025 Shared package dsm_pkg SHALL hold:
  - the Out_Div width constant (4);
  - the LFSR width, seed and tap constants;
  - the maximum ORDER constant.
REQ-026 The single sub-module dsm_accum_stage SHALL implement one WIDTH-bit accumulator with registered carry and enable, exposing its next-state sum.
REQ-027 mash_dsm SHALL instantiate ORDER copies of dsm_accum_stage via generate.

Verification
REQ-028 WIDTH=7, ORDER=1, In_Data=1, En=1, reset released at cycle 0: Out_Div=1 exactly once per 128 cycles, first at cycle 129; 0 otherwise.
REQ-029 WIDTH=7, ORDER=1, In_Data=127: Out_Div=1 on 127 of every 128 cycles once filled.
REQ-030 WIDTH=7, ORDER=3, In_Data=64, no dither: Out_Div always within -3..+4; the sum over any 1024 consecutive valid cycles is 512 +/- 3; Out_Valid rises on the 4th enabled edge.
REQ-031 WIDTH=7, ORDER=3, In_Data=0, no dither: Out_Div=0 and all accumulators 0 for 500 cycles.
REQ-032 Toggle En low for 10 cycles mid-run: all outputs frozen; the sequence resumes exactly where it stopped, matching a reference model.
REQ-033 Assert reset for 1 cycle at cycle 300 with In_Data=1, ORDER=3: Out_Div=0 and Out_Valid=0 the next cycle, after which the trace matches a fresh run from cycle 0.
